// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the write-back register file and its benches.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register: never written, always reads 0.
  localparam int ZERO_REG = 0;

  // Named register indices for directed stimulus.
  localparam int REG_T0 = 8;
  localparam int REG_T1 = 9;
  localparam int REG_T2 = 10;
  localparam int REG_RA = 31;

endpackage : wb_regfile_pkg

// File: rtl/regfile_read_port.sv
// One decode-side read port: zero-register check, write-back bypass, entry select.
// Latency: purely combinational; the top registers the result.
// Backpressure: none; the caller decides whether the selected value is loaded.
module regfile_read_port
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  entries,
  output logic [DATA_W-1:0]                   rd_data
);

  // Register 0 reads 0; a same-cycle committed write to the named register wins over storage.
  always_comb begin
    rd_data = '0;
    if (rd_addr != ADDR_W'(ZERO_REG)) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data = wr_data;
      end else begin
        rd_data = entries[rd_addr];
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/wb_regfile.sv
// Integer register file fed by write-back, with two bypassed, registered decode read ports.
// Latency: 1 cycle from rs_addr/rt_addr to rs_data/rt_data; writes land on the same edge.
// Backpressure: stall holds the operand latch, flush zeroes it; write-back always retires.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]           rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0]           rs_sel, rt_sel;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        wr_en;

  // A write commits only when enabled and not aimed at the zero register.
  assign wr_en = wb_regwrite && (wb_rd != ADDR_W'(ZERO_REG));

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_rs (
    .rd_addr (rs_addr),
    .wr_en   (wr_en),
    .wr_addr (wb_rd),
    .wr_data (wb_data),
    .entries (mem_q),
    .rd_data (rs_sel)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_rt (
    .rd_addr (rt_addr),
    .wr_en   (wr_en),
    .wr_addr (wb_rd),
    .wr_data (wb_data),
    .entries (mem_q),
    .rd_data (rt_sel)
  );

  // Next storage state: the committed write updates its entry regardless of stall/flush.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wb_rd] = wb_data;
    end
  end

  // Operand latch next state: flush beats stall, stall beats a fresh load.
  always_comb begin
    rs_d = rs_q;
    rt_d = rt_q;
    if (flush) begin
      rs_d = '0;
      rt_d = '0;
    end else if (!stall) begin
      rs_d = rs_sel;
      rt_d = rt_sel;
    end
  end

  // Retired-write counter wraps naturally at its width.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(wr_en);
  end

  // All state clears asynchronously; reset also drops any write presented that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      cnt_q <= cnt_d;
    end
  end

  assign rs_data  = rs_q;
  assign rt_data  = rt_q;
  assign wr_count = cnt_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios then randomized traffic.
// Expected operands and counter come from an array-based architectural model.
// A monitor pops one expectation per clock edge and compares it with the outputs.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          wb_regwrite;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          stall;
  logic          flush;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [CW-1:0] wr_count;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .stall       (stall),
    .flush       (flush),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Architectural model state
  logic [31:0] m_mem [32];
  logic [31:0] m_rs, m_rt;
  int          m_cnt;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_rs  = 32'h0;
    m_rt  = 32'h0;
    m_cnt = 0;
  endfunction

  // Value a read of register a sees at the edge, given the write presented in that cycle.
  function automatic logic [31:0] model_read(input int a, input bit we, input int rd, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (we && rd != 0 && rd == a) return d;
    return m_mem[a];
  endfunction

  // Advance the model by one clock edge and queue the expected outputs.
  function automatic void model_step();
    exp_t e;
    bit committed;
    logic [31:0] nrs, nrt;
    committed = wb_regwrite && (int'(wb_rd) != 0);
    if (flush) begin
      nrs = 32'h0;
      nrt = 32'h0;
    end else if (stall) begin
      nrs = m_rs;
      nrt = m_rt;
    end else begin
      nrs = model_read(int'(rs_addr), wb_regwrite, int'(wb_rd), wb_data);
      nrt = model_read(int'(rt_addr), wb_regwrite, int'(wb_rd), wb_data);
    end
    m_rs = nrs;
    m_rt = nrt;
    if (committed) begin
      m_mem[int'(wb_rd)] = wb_data;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    step_id++;
    e.id = step_id; e.rs = m_rs; e.rt = m_rt; e.cnt = m_cnt;
    exp_q.push_back(e);
  endfunction

  function automatic void push_reset_exp();
    exp_t e;
    model_clear();
    step_id++;
    e.id = step_id; e.rs = 32'h0; e.rt = 32'h0; e.cnt = 0;
    exp_q.push_back(e);
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, want);
    end
  endtask

  // Monitor: one expectation per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty t=%0t got=0 exp=1", $time);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("rs_data#%0d", e.id), rs_data, e.rs);
        check_val($sformatf("rt_data#%0d", e.id), rt_data, e.rt);
        check_val($sformatf("wr_count#%0d", e.id), {28'h0, wr_count}, e.cnt[31:0]);
      end
    end
  end

  task automatic cyc(input bit we, input int rd, input logic [31:0] d,
                     input int a, input int b, input bit st, input bit fl);
    @(negedge clk);
    rst         = 1'b0;
    wb_regwrite = we;
    wb_rd       = AW'(rd);
    wb_data     = d;
    rs_addr     = AW'(a);
    rt_addr     = AW'(b);
    stall       = st;
    flush       = fl;
    model_step();
  endtask

  // Reset raised between edges while a write is presented; outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    wb_regwrite = 1'b1;
    wb_rd       = AW'(12);
    wb_data     = 32'hABCD_0123;
    rs_addr     = AW'(REG_T0);
    rt_addr     = AW'(12);
    stall       = 1'b0;
    flush       = 1'b0;
    push_reset_exp();
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_rs", rs_data, 32'h0);
    check_val("async_rst_rt", rt_data, 32'h0);
    check_val("async_rst_cnt", {28'h0, wr_count}, 32'h0);
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return REG_T0;
      2: return REG_T1;
      3: return REG_RA;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    rs_addr = '0; rt_addr = '0; stall = 1'b0; flush = 1'b0;
    push_reset_exp();
    #1;
    check_val("reset_rs", rs_data, 32'h0);
    check_val("reset_rt", rt_data, 32'h0);
    check_val("reset_cnt", {28'h0, wr_count}, 32'h0);

    // Write then read back
    cyc(1, REG_T0, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(0, 0, 32'h0, REG_T0, 0, 0, 0);
    // Same-cycle bypass, both ports on the same register
    cyc(1, REG_T1, 32'h11111111, 0, 0, 0, 0);
    cyc(1, REG_T1, 32'h22222222, REG_T1, REG_T1, 0, 0);
    cyc(0, 0, 32'h0, REG_T1, REG_T0, 0, 0);
    // Register 0 neither written, counted nor bypassed
    cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    cyc(0, 0, 32'h0, 0, REG_T0, 0, 0);
    // Stall holds despite a write to the source register; release shows the new value
    cyc(1, REG_T2, 32'h5, 0, 0, 0, 0);
    cyc(0, 0, 32'h0, REG_T2, REG_T2, 0, 0);
    cyc(1, REG_T2, 32'h7, REG_T2, REG_T2, 1, 0);
    cyc(0, 0, 32'h0, REG_T2, REG_T2, 0, 0);
    // Flush wins over stall; write still retires under flush
    cyc(1, REG_RA, 32'hCAFEF00D, REG_T2, REG_T0, 1, 1);
    cyc(0, 0, 32'h0, REG_RA, REG_T2, 0, 0);
    // Counter wrap: 17 writes to register 3
    for (int i = 0; i < 17; i++) cyc(1, 3, 32'h100 + i, 3, 0, 0, 0);
    cyc(0, 0, 32'h0, 3, 3, 0, 0);
    // Asynchronous reset mid-operation, then confirm every entry reads 0
    mid_reset();
    for (int i = 0; i < 32; i++) cyc(0, 0, 32'h0, i, 31 - i, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 1) == 1, pick_addr(), $urandom(),
          pick_addr(), pick_addr(),
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      if (n == 700) mid_reset();
    end

    // Final sweep of the whole file
    for (int i = 0; i < 32; i++) cyc(0, 0, 32'h0, i, 31 - i, 0, 0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Integer register file that consumes the write-back stage result: wb_data, destination register and RegWrite from the MEM/WB latch.
- Provides two read ports for the decode stage and registers the read operands into the decode-side operand latch.
- Includes same-cycle write-to-read bypass, so a write-back and a dependent decode in the same cycle need no extra stall.
- Honours pipeline stall and flush, and counts retired writes for debug.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; the file holds 2**ADDR_W entries.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_regwrite  input  1  write enable from MEM/WB (RegWrite).
- wb_rd  input  ADDR_W  destination register index from MEM/WB.
- wb_data  input  DATA_W  write-back value, i.e. the MemtoReg mux output.
- rs_addr  input  ADDR_W  read port A index (instruction rs field).
- rt_addr  input  ADDR_W  read port B index (instruction rt field).
- stall  input  1  hold the operand outputs this cycle.
- flush  input  1  zero the operand outputs this cycle (bubble).
- rs_data  output  DATA_W  registered read value, port A.
- rt_data  output  DATA_W  registered read value, port B.
- wr_count  output  CNT_W  number of committed writes to non-zero registers.

Behaviour:
- Reset:
  - Asynchronous on rst high, independent of clk.
  - All 2**ADDR_W entries, rs_data, rt_data and wr_count go to 0.
  - Reset asserted mid-operation discards any in-flight write in that cycle.
- Write:
  - Occurs on the rising edge when wb_regwrite=1 and wb_rd!=0: entry[wb_rd] <= wb_data.
  - Writes to index 0 are ignored. Entry 0 always reads 0.
  - Writes are unaffected by stall and flush; write-back always retires.
- Read: combinational select, then registered. rs_data/rt_data update on the rising edge, giving 1-cycle latency from address to output.
- Bypass:
  - If wb_regwrite=1, wb_rd!=0 and wb_rd==rs_addr in the same cycle, rs_data captures wb_data instead of the stale entry. Same rule for rt.
  - If both ports name the same register, both get the bypassed value.
  - Index 0 is never bypassed; it reads 0 even if wb_rd==0 with wb_regwrite=1.
- Output priority each edge: rst > flush > stall > normal load.
  - flush=1: rs_data=rt_data=0, even if stall=1.
  - stall=1, flush=0: rs_data and rt_data hold their previous value.
  - A write to a register the held outputs came from does not alter them during stall; the new value appears after stall releases, if the address is still presented.
- Counter:
  - wr_count increments by 1 on each committed write (wb_regwrite=1, wb_rd!=0).
  - Wraps modulo 2**CNT_W with no saturation.
  - Not affected by stall or flush.
- Widths: no arithmetic on data; all data paths are exactly DATA_W with no truncation or extension.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and ADDR_W defaults.
  - The constant ZERO_REG = 0.
  - Named register indices used in benches (e.g. REG_T0=8, REG_RA=31).
- One natural sub-module: regfile_read_port (bypass compare, zero-register check and entry select), instantiated twice for rs and rt.
- Storage, the operand output registers and the counter stay in the top module.

Test Plan:
- Reset: assert rst asynchronously between edges with data loaded -> rs_data, rt_data and wr_count read 0 immediately; all entries read 0 after release.
- Write then read: wb_regwrite=1, wb_rd=8, wb_data=0xDEADBEEF; next cycle rs_addr=8 -> rs_data=0xDEADBEEF one edge later; wr_count=1.
- Same-cycle bypass:
  - Step 1: entry 9 holds 0x11111111.
  - Step 2: present wb_rd=9, wb_data=0x22222222, rs_addr=rt_addr=9 in the same cycle.
  - Required response: rs_data=rt_data=0x22222222 after the edge.
- Register 0: wb_regwrite=1, wb_rd=0, wb_data=0xFFFFFFFF with rs_addr=0 -> rs_data=0 and wr_count unchanged.
- Stall/flush:
  - Step 1: rs_data=0x5; assert stall and write 0x7 to the same register -> rs_data stays 0x5.
  - Step 2: release stall -> rs_data=0x7.
  - Step 3: assert stall and flush together -> rs_data=rt_data=0.
- Counter wrap: with CNT_W=4, perform 17 writes to register 3 -> wr_count=1.
